alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the execute-stage ALU.
- Operands and opcode are captured on a valid/ready handshake.
- Single-cycle ops produce a registered result one cycle after accept; MUL runs as an iterative shift-add over WIDTH cycles.
- Sits between decode/register-read and writeback; downstream stalls are absorbed by the output handshake.

Parameters:
- WIDTH, 32, datapath width in bits (power of 2, >= 8).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept an op
- control  in  4  opcode
- oper1  in  WIDTH  operand A
- oper2  in  WIDTH  operand B (shift amount = oper2[SHW-1:0])
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  result
- overflow  out  1  signed overflow (ADD/SUB); product exceeds WIDTH bits (MUL)
- carry  out  1  carry-out (ADD); borrow, i.e. oper1 < oper2 unsigned (SUB)
- zero  out  1  result == 0
- illegal  out  1  unsupported opcode
- busy  out  1  state != IDLE

Behaviour:
- Reset: when rst_n is sampled low at a clk edge:
  - state = IDLE.
  - out_valid, result, overflow, carry, zero, illegal and busy all = 0.
  - MUL counter and accumulator are cleared.
  - An in-flight op is dropped silently and never produces out_valid.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits, unsigned), 3 AND, 4 OR, 5 XOR.
  - 6 SLT: signed; result = 1 or 0.
  - 7 SLL, 8 SRL, 9 SRA.
  - 10-15 are illegal.
- Flags:
  - overflow and carry are 0 for every op other than those listed for them.
  - zero is computed from the final result for all ops, including illegal ones.
- Illegal opcode: result = 0, zero = 1, illegal = 1, single-cycle timing. illegal = 0 for all legal ops.
- Accept: occurs when in_valid && in_ready. in_ready = (state == IDLE).
  - On accept, control, oper1 and oper2 are registered.
  - Input changes after accept have no effect.
- States:
  - IDLE: on accept, a non-MUL op goes to DONE with result and flags registered that edge, so out_valid rises 1 cycle after accept. A MUL goes to MUL_RUN with acc = 0 and cnt = 0.
  - MUL_RUN: each cycle, if multiplier bit cnt is set, acc += multiplicand << cnt, using a 2*WIDTH-bit accumulator; cnt increments. After WIDTH iterations go to DONE with result = acc[WIDTH-1:0] and overflow = |acc[2W-1:W]. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE: out_valid = 1; result and flags are held stable. On out_valid && out_ready go to IDLE, and out_valid = 0 the next cycle.
- in_valid outside IDLE is ignored; the op is not queued. The source must hold in_valid until in_ready.
- Minimum initiation interval: 2 cycles (single-cycle op with out_ready tied high).
- Outputs other than out_valid hold their last value in IDLE. They change only on DONE entry or on reset.
- Reset asserted in the same cycle as accept or completion wins: no output is produced.
- Shifts:
  - A shift amount of 0 returns oper1 unchanged.
  - SRA replicates oper1[WIDTH-1].
  - Amount bits above SHW are ignored.

Test Plan:
- WIDTH=32: ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept; result 0x80000000, overflow 1, carry 0, zero 0. ADD 0xFFFFFFFF + 1 -> result 0, carry 1, zero 1, overflow 0.
- SUB 5 - 5 -> result 0, zero 1, carry 0. SUB 3 - 5 -> result 0xFFFFFFFE, carry 1, overflow 0. SLT 0xFFFFFFFF vs 1 -> result 1.
- MUL 0x00010000 * 0x00010000 -> in_ready 0 and busy 1 for 33 cycles; out_valid on cycle 33 after accept; result 0, overflow 1, zero 1. MUL 1234 * 5678 -> 7006652, overflow 0.
- Backpressure: hold out_ready 0 for 5 cycles after out_valid, with in_valid pulsed carrying a new op -> result and flags stable, in_ready 0, new op not taken. Raise out_ready -> out_valid drops and in_ready is 1 the next cycle.
- Reset: rst_n low at cycle 10 of a MUL -> next cycle state IDLE, out_valid 0, result 0; out_valid never asserts for the aborted op. The first op after reset completes normally.
- Shifts and illegal: SRA 0x80000000 by 4 -> 0xF8000000; SRL same -> 0x08000000; SLL 1 by 37 (amount 5) -> 0x00000020. control = 15 -> result 0, illegal 1, zero 1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle ops answer one cycle after
// accept, MUL iterates shift-add over WIDTH cycles behind a handshake.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  op handshake (ready only in IDLE)
//   control              opcode (0..9 legal, 10..15 illegal)
//   oper1, oper2         operands; oper2[SHW-1:0] is the shift amount
//   out_valid/out_ready  result handshake, held in DONE until taken
//   result               datapath result
//   overflow             signed ovf (ADD/SUB), product > WIDTH bits (MUL)
//   carry                carry-out (ADD), borrow (SUB)
//   zero, illegal, busy  result==0, bad opcode, not IDLE
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] oper1,
   input  logic [WIDTH-1:0] oper2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             carry,
   output logic             zero,
   output logic             illegal,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL_RUN,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               cry_q, cry_d;
   logic               zero_q, zero_d;
   logic               ill_q, ill_d;

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SHW-1:0]     cnt_q, cnt_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic               alu_cry;
   logic               alu_ill;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [SHW-1:0]     shamt;
   logic [2*WIDTH-1:0] acc_nxt;
   logic               accept;

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;

   assign result   = result_q;
   assign overflow = ovf_q;
   assign carry    = cry_q;
   assign zero     = zero_q;
   assign illegal  = ill_q;

   // Single-cycle datapath straight off the input operands.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_cry = 1'b0;
      alu_ill = 1'b0;
      shamt   = oper2[SHW-1:0];
      sum     = {1'b0, oper1} + {1'b0, oper2};
      dif     = {1'b0, oper1} - {1'b0, oper2};
      case (control)
         4'd0: begin
            alu_res = sum[WIDTH-1:0];
            alu_cry = sum[WIDTH];
            alu_ovf = (oper1[WIDTH-1] == oper2[WIDTH-1]) &&
                      (sum[WIDTH-1] != oper1[WIDTH-1]);
         end
         4'd1: begin
            alu_res = dif[WIDTH-1:0];
            // top bit of the widened difference is the unsigned borrow
            alu_cry = dif[WIDTH];
            alu_ovf = (oper1[WIDTH-1] != oper2[WIDTH-1]) &&
                      (dif[WIDTH-1] != oper1[WIDTH-1]);
         end
         4'd2: alu_res = '0;
         4'd3: alu_res = oper1 & oper2;
         4'd4: alu_res = oper1 | oper2;
         4'd5: alu_res = oper1 ^ oper2;
         4'd6: alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(oper1) < $signed(oper2))};
         4'd7: alu_res = oper1 << shamt;
         4'd8: alu_res = oper1 >> shamt;
         4'd9: alu_res = $unsigned($signed(oper1) >>> shamt);
         default: alu_ill = 1'b1;
      endcase
   end

   // Multiplicand shifts left and multiplier right each step, so the
   // partial product add never needs a barrel shifter.
   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      cry_d    = cry_q;
      zero_d   = zero_q;
      ill_d    = ill_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (control == 4'd2) begin
                  state_d  = MUL_RUN;
                  acc_d    = '0;
                  cnt_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, oper1};
                  mplier_d = oper2;
               end else begin
                  state_d  = DONE;
                  result_d = alu_res;
                  ovf_d    = alu_ovf;
                  cry_d    = alu_cry;
                  ill_d    = alu_ill;
                  zero_d   = (alu_res == '0);
               end
            end
         end
         MUL_RUN: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               cnt_d    = '0;
               result_d = acc_nxt[WIDTH-1:0];
               ovf_d    = |acc_nxt[2*WIDTH-1:WIDTH];
               cry_d    = 1'b0;
               ill_d    = 1'b0;
               zero_d   = (acc_nxt[WIDTH-1:0] == '0);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         cry_q    <= 1'b0;
         zero_q   <= 1'b0;
         ill_q    <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         cry_q    <= cry_d;
         zero_q   <= zero_d;
         ill_q    <= ill_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus random ops, all outputs
// compared every cycle against a latency/arithmetic model.
module tb_alu_seq;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  control;
   logic [31:0] oper1;
   logic [31:0] oper2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        carry;
   logic        zero;
   logic        illegal;
   logic        busy;

   logic rnd_ready = 1'b0;
   logic ready_force = 1'b1;
   logic rnd_bit = 1'b1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign out_ready = rnd_ready ? rnd_bit : ready_force;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
   end

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .control(control),
      .oper1(oper1),
      .oper2(oper2),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .overflow(overflow),
      .carry(carry),
      .zero(zero),
      .illegal(illegal),
      .busy(busy)
   );

   function automatic void calc(
      input  logic [3:0]  c,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic [31:0] r,
      output bit          o,
      output bit          cy,
      output bit          il
   );
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint unsigned ua = {32'b0, a};
      longint unsigned ub = {32'b0, b};
      longint unsigned p;
      longint s;
      int sh = int'(b[4:0]);
      int t;
      r = '0;
      o = 0;
      cy = 0;
      il = 0;
      case (c)
         4'd0: begin
            s = sa + sb;
            p = ua + ub;
            r = p[31:0];
            cy = (p >> 32) != 0;
            o = (s > SMAX) || (s < SMIN);
         end
         4'd1: begin
            s = sa - sb;
            r = a - b;
            cy = ua < ub;
            o = (s > SMAX) || (s < SMIN);
         end
         4'd2: begin
            p = ua * ub;
            r = p[31:0];
            o = (p >> 32) != 0;
         end
         4'd3: r = a & b;
         4'd4: r = a | b;
         4'd5: r = a ^ b;
         4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd7: r = a << sh;
         4'd8: r = a >> sh;
         4'd9: begin
            t = $signed(a);
            t = t >>> sh;
            r = t;
         end
         default: il = 1;
      endcase
   endfunction

   // Model: what the outputs must be, from op arithmetic and latency.
   bit          m_init = 0;
   bit          m_idle = 1;
   bit          m_vld = 0;
   int          m_left = 0;
   logic [31:0] e_res = '0;
   bit          e_o = 0;
   bit          e_c = 0;
   bit          e_z = 0;
   bit          e_i = 0;
   logic [31:0] p_res;
   bit          p_o;
   bit          p_c;
   bit          p_i;

   function automatic void complete();
      e_res = p_res;
      e_o = p_o;
      e_c = p_c;
      e_i = p_i;
      e_z = (p_res == 0);
      m_vld = 1;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_init = 1;
         m_idle = 1;
         m_vld = 0;
         m_left = 0;
         e_res = '0;
         e_o = 0;
         e_c = 0;
         e_z = 0;
         e_i = 0;
      end else if (m_init) begin
         if (m_vld) begin
            if (out_ready) begin
               m_vld = 0;
               m_idle = 1;
            end
         end else if (!m_idle) begin
            m_left--;
            if (m_left == 0) complete();
         end else if (in_valid) begin
            calc(control, oper1, oper2, p_res, p_o, p_c, p_i);
            m_idle = 0;
            if (control == 4'd2) m_left = 32;
            else complete();
         end
      end
   end

   logic [40:0] got_v;
   logic [40:0] exp_v;

   always @(negedge clk) begin
      if (m_init) begin
         got_v = {out_valid, in_ready, busy, result,
                  overflow, carry, zero, illegal};
         exp_v = {m_vld, m_idle, !m_idle, e_res, e_o, e_c, e_z, e_i};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL cycle t=%0t got=%h exp=%h", $time, got_v, exp_v);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b);
      int n;
      n = 0;
      @(negedge clk);
      control = c;
      oper1 = a;
      oper2 = b;
      in_valid = 1'b1;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         failures++;
         $display("FAIL issue_timeout got=busy exp=ready");
      end
      @(negedge clk);
      in_valid = 1'b0;
      control = 4'($urandom);
      oper1 = $urandom;
      oper2 = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef,
                         input int elat);
      int lat;
      issue(c, a, b);
      wait_done(lat);
      chk({name, "_lat"}, lat, elat);
      chk({name, "_res"}, result, er);
      chk({name, "_flags"}, {28'd0, overflow, carry, zero, illegal},
          {28'd0, ef});
      @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'h7FFFFFFF;
         3: return 32'h80000000;
         4: return 32'hFFFFFFFF;
         5: return $urandom_range(0, 40);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int cnt;
      logic [3:0] c;
      rst_n = 1'b0;
      in_valid = 1'b0;
      control = '0;
      oper1 = '0;
      oper2 = '0;
      repeat (2) @(negedge clk);
      chk("reset_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
      chk("reset_result", result, 32'h0);
      rst_n = 1'b1;

      // flags order: overflow, carry, zero, illegal
      run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1000, 1);
      run_op("add_cry", 4'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 1);
      run_op("sub_eq", 4'd1, 32'd5, 32'd5, 32'h0, 4'b0010, 1);
      run_op("sub_brw", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0100, 1);
      run_op("slt", 4'd6, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000, 1);
      run_op("mul_big", 4'd2, 32'h00010000, 32'h00010000, 32'h0, 4'b1010, 33);
      run_op("sra", 4'd9, 32'h80000000, 32'd4, 32'hF8000000, 4'b0000, 1);
      run_op("srl", 4'd8, 32'h80000000, 32'd4, 32'h08000000, 4'b0000, 1);
      run_op("sll", 4'd7, 32'h1, 32'd37, 32'h00000020, 4'b0000, 1);
      run_op("ill", 4'd15, 32'h1234, 32'h5678, 32'h0, 4'b0011, 1);
      run_op("mul", 4'd2, 32'd1234, 32'd5678, 32'd7006652, 4'b0000, 33);

      // reset in the middle of a MUL
      issue(4'd2, 32'd3, 32'd5);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_mul_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
      chk("rst_mul_result", result, 32'h0);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("rst_no_valid", cnt, 0);
      run_op("post_rst", 4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1);

      // backpressure with a new op pulsed while DONE
      ready_force = 1'b0;
      issue(4'd0, 32'd7, 32'd8);
      wait_done(cnt);
      repeat (5) begin
         in_valid = 1'b1;
         control = 4'd3;
         oper1 = 32'hFFFF;
         oper2 = 32'hF0F0;
         @(negedge clk);
         chk("bp_hold", {27'd0, out_valid, in_ready, busy, 2'b0},
             {27'd0, 3'b101, 2'b0});
         chk("bp_res", result, 32'd15);
      end
      in_valid = 1'b0;
      ready_force = 1'b1;
      @(negedge clk);
      chk("bp_release", {29'd0, out_valid, in_ready, busy}, 32'b010);

      // random ops, random consumer stalls
      rnd_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         c = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15))
                                         : 4'($urandom_range(0, 9));
         issue(c, pick(), pick());
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rnd_ready = 1'b0;
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("drain", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
